// File: rtl/watch_set_ctrl.sv
// watch_set_ctrl: edit-mode FSM issuing single-cycle up/down pulses, field select and blink for watch time setting.
// Optional auto-repeat on held up/down is built only when WATCH_SET_CTRL_AUTOREPEAT_EN is defined.
module watch_set_ctrl #(
  parameter int unsigned HOLD_CYCLES    = 50_000_000,
  parameter int unsigned REPEAT_CYCLES  = 10_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000,
  parameter int unsigned BLINK_CYCLES   = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  output logic       o_hour_up,
  output logic       o_hour_down,
  output logic       o_min_up,
  output logic       o_min_down,
  output logic       o_sec_up,
  output logic       o_sec_down,
  output logic [1:0] o_edit_field,
  output logic       o_blink_on
);
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int BW = BLINK_CYCLES > 1 ? $clog2(BLINK_CYCLES) : 1;
  typedef enum logic [1:0] {RUN, EDIT_HOUR, EDIT_MIN, EDIT_SEC} state_t;
  state_t        state_q, state_d;
  logic          mode_q, up_q, down_q;
  logic [TW-1:0] to_q, to_d;
  logic [BW-1:0] bl_q, bl_d;
  logic          blink_q, blink_d;
  logic [5:0]    pulse_q, pulse_d;
  logic          mode_e, up_e, down_e, edit, ok, any_btn, timeout, rep_fire, up_p, down_p, restart, bl_end;
  assign mode_e  = i_btn_mode & ~mode_q;
  assign up_e    = i_btn_up & ~up_q;
  assign down_e  = i_btn_down & ~down_q;
  assign any_btn = i_btn_mode | i_btn_up | i_btn_down;
  assign edit    = state_q != RUN;
  assign ok      = edit & ~mode_e;
  assign timeout = edit & ~any_btn & (to_q == TW'(TIMEOUT_CYCLES - 1));
  // both buttons high cancels either pulse
  assign up_p    = ok & i_btn_up & ~i_btn_down & (up_e | rep_fire);
  assign down_p  = ok & i_btn_down & ~i_btn_up & (down_e | rep_fire);
`ifdef WATCH_SET_CTRL_AUTOREPEAT_EN
  localparam int unsigned HMAX = HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW = HMAX > 1 ? $clog2(HMAX) : 1;
  logic [HW-1:0] hold_q, hold_d;
  logic          arm_q, arm_d, rep_q, rep_d, keep;
  assign keep     = ok & (i_btn_up ^ i_btn_down);
  // armed only by a press edge, so a button left over after a two-button press never repeats
  assign rep_fire = arm_q & (hold_q == (rep_q ? HW'(REPEAT_CYCLES - 1) : HW'(HOLD_CYCLES - 1)));
  always_comb begin
    arm_d  = keep & (arm_q | up_e | down_e);
    hold_d = (!arm_d || up_e || down_e || rep_fire) ? '0 : hold_q + 1'b1;
    rep_d  = arm_d & ~up_e & ~down_e & (rep_q | rep_fire);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_q <= '0;
      arm_q  <= 1'b0;
      rep_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      arm_q  <= arm_d;
      rep_q  <= rep_d;
    end
  end
`else
  logic unused_params;
  assign unused_params = ^{HOLD_CYCLES, REPEAT_CYCLES};
  assign rep_fire = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      mode_q  <= 1'b0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      to_q    <= '0;
      bl_q    <= '0;
      blink_q <= 1'b1;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= i_btn_mode;
      up_q    <= i_btn_up;
      down_q  <= i_btn_down;
      to_q    <= to_d;
      bl_q    <= bl_d;
      blink_q <= blink_d;
      pulse_q <= pulse_d;
    end
  end
  always_comb state_d = mode_e ? state_t'(state_q + 2'd1) : timeout ? RUN : state_q;
  always_comb begin
    to_d    = (!edit || any_btn || timeout) ? '0 : to_q + 1'b1;
    pulse_d = {up_p & (state_q == EDIT_HOUR), down_p & (state_q == EDIT_HOUR),
               up_p & (state_q == EDIT_MIN),  down_p & (state_q == EDIT_MIN),
               up_p & (state_q == EDIT_SEC),  down_p & (state_q == EDIT_SEC)};
    restart = (state_d == RUN) | (state_d != state_q) | up_p | down_p;
    bl_end  = bl_q == BW'(BLINK_CYCLES - 1);
    bl_d    = (restart || bl_end) ? '0 : bl_q + 1'b1;
    blink_d = restart ? 1'b1 : bl_end ? ~blink_q : blink_q;
  end
  assign {o_hour_up, o_hour_down, o_min_up, o_min_down, o_sec_up, o_sec_down} = pulse_q;
  assign o_edit_field = state_q;
  assign o_blink_on   = blink_q;
endmodule

// File: tb/tb_watch_set_ctrl.sv
// tb_watch_set_ctrl: directed scenarios plus random button traffic checked against an event-time reference model.
module tb_watch_set_ctrl;
  localparam int HOLD = 8, REP = 4, TO = 32, BL = 5;
`ifdef WATCH_SET_CTRL_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, i_btn_mode = 1'b0, i_btn_up = 1'b0, i_btn_down = 1'b0;
  logic o_hour_up, o_hour_down, o_min_up, o_min_down, o_sec_up, o_sec_down, o_blink_on;
  logic [1:0] o_edit_field;
  watch_set_ctrl #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .TIMEOUT_CYCLES(TO), .BLINK_CYCLES(BL)) dut (
    .clk(clk), .rst(rst), .i_btn_mode(i_btn_mode), .i_btn_up(i_btn_up), .i_btn_down(i_btn_down),
    .o_hour_up(o_hour_up), .o_hour_down(o_hour_down), .o_min_up(o_min_up), .o_min_down(o_min_down),
    .o_sec_up(o_sec_up), .o_sec_down(o_sec_down), .o_edit_field(o_edit_field), .o_blink_on(o_blink_on));
  always #5 clk = ~clk;
  wire [5:0] pulses = {o_hour_up, o_hour_down, o_min_up, o_min_down, o_sec_up, o_sec_down};
  wire [8:0] obs = {pulses, o_edit_field, o_blink_on};
  int n_cmp = 0, n_err = 0;
  // reference model: field, times of last activity / blink restart / press, in absolute cycles
  int cyc = 0, field_m = 0, last_act = 0, blink_start = 0, press = 0;
  bit pm, pu, pd, hold_v, blink_m = 1'b1;
  logic [5:0] pulse_m = '0;
  logic [8:0] mdl = 9'b000000001;

  task automatic step(input bit rn, input bit m, input bit u, input bit d);
    bit me, ue, de, edit, up, dn;
    int nf;
    @(negedge clk);
    rst = rn; i_btn_mode = m; i_btn_up = u; i_btn_down = d;
    @(posedge clk);
    cyc++;
    if (!rn) begin
      field_m = 0; pulse_m = '0; blink_m = 1'b1; pm = 0; pu = 0; pd = 0; hold_v = 0;
    end else begin
      me = m && !pm; ue = u && !pu; de = d && !pd;
      edit = field_m != 0;
      up = 0; dn = 0;
      if (edit && !me && u && !d) begin
        if (ue) begin up = 1; hold_v = 1; press = cyc; end
        else if (AR && hold_v && cyc - press >= HOLD && (cyc - press - HOLD) % REP == 0) up = 1;
      end else if (edit && !me && d && !u) begin
        if (de) begin dn = 1; hold_v = 1; press = cyc; end
        else if (AR && hold_v && cyc - press >= HOLD && (cyc - press - HOLD) % REP == 0) dn = 1;
      end else hold_v = 0;
      pulse_m = '0;
      if (up) pulse_m[7 - 2 * field_m] = 1'b1;
      if (dn) pulse_m[6 - 2 * field_m] = 1'b1;
      if (m || u || d) last_act = cyc;
      nf = field_m;
      if (me) nf = (field_m + 1) % 4;
      else if (edit && cyc - last_act >= TO) nf = 0;
      if (nf != field_m || up || dn || nf == 0) blink_start = cyc;
      field_m = nf;
      blink_m = (nf == 0) ? 1'b1 : (((cyc - blink_start) / BL) % 2 == 0);
      pm = m; pu = u; pd = d;
    end
    mdl = {pulse_m, field_m[1:0], blink_m};
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
      n_cmp++;
      if (obs !== 9'b000000001) begin n_err++; $display("FAIL reset_state cyc=%0d got=%b exp=%b", cyc, obs, 9'b000000001); end
    end
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    n_cmp++;
    if (pulses !== 6'd0 || obs !== mdl) begin n_err++; $display("FAIL run_up_ignored got=%b exp=%b", obs, mdl); end
    step(1, 0, 0, 0);
  endtask

  task automatic test_mode();
    int exp_f[4] = '{1, 2, 3, 0};
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 0);
      n_cmp++;
      if (o_edit_field !== 2'(exp_f[i]) || obs !== mdl) begin n_err++; $display("FAIL mode_step%0d field=%0d exp=%0d obs=%b mdl=%b", i, o_edit_field, exp_f[i], obs, mdl); end
      step(1, 0, 0, 0); step(1, 0, 0, 0);
      n_cmp++;
      if (o_edit_field !== 2'(exp_f[i])) begin n_err++; $display("FAIL mode_hold_field%0d field=%0d exp=%0d", i, o_edit_field, exp_f[i]); end
    end
    for (int i = 0; i < 20; i++) step(1, 1, 0, 0);
    n_cmp++;
    if (o_edit_field !== 2'd1 || obs !== mdl) begin n_err++; $display("FAIL mode_held_once field=%0d exp=1 obs=%b mdl=%b", o_edit_field, obs, mdl); end
    step(1, 0, 0, 0);
  endtask

  task automatic test_field_pulse();
    step(1, 1, 0, 0); step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    n_cmp++;
    if (pulses !== 6'b001000 || o_edit_field !== 2'd2) begin n_err++; $display("FAIL min_up_pulse got=%b exp=001000 field=%0d", pulses, o_edit_field); end
    step(1, 0, 0, 0);
    n_cmp++;
    if (pulses !== 6'd0) begin n_err++; $display("FAIL min_up_single got=%b exp=000000", pulses); end
    step(1, 0, 0, 1);
    n_cmp++;
    if (pulses !== 6'b000100 || obs !== mdl) begin n_err++; $display("FAIL min_down_pulse got=%b exp=000100", pulses); end
    step(1, 0, 0, 0);
    n_cmp++;
    if (pulses !== 6'd0) begin n_err++; $display("FAIL min_down_single got=%b exp=000000", pulses); end
  endtask

  task automatic test_autorepeat();
    logic [20:0] seen = '0, exp_m;
    exp_m = AR ? 21'((1 << 1) | (1 << 9) | (1 << 13) | (1 << 17)) : 21'(1 << 1);
    step(1, 1, 0, 0); step(1, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      step(1, 0, 1, 0);
      seen[i] = o_sec_up;
      n_cmp++;
      if (obs !== mdl) begin n_err++; $display("FAIL hold_cycle%0d got=%b exp=%b", i, obs, mdl); end
    end
    n_cmp++;
    if (seen !== exp_m) begin n_err++; $display("FAIL sec_up_repeat_pattern got=%b exp=%b", seen, exp_m); end
    step(1, 0, 0, 0);
  endtask

  task automatic test_timeout_blink();
    step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
    for (int j = 1; j < 20; j++) begin
      step(1, 0, 0, 0);
      n_cmp++;
      if (o_edit_field !== 2'd1 || o_blink_on !== ((j / BL) % 2 == 0) || obs !== mdl)
        begin n_err++; $display("FAIL blink_idle j=%0d obs=%b mdl=%b", j, obs, mdl); end
    end
    step(1, 0, 1, 0);
    n_cmp++;
    if (pulses !== 6'b100000 || o_blink_on !== 1'b1) begin n_err++; $display("FAIL hour_up_restart got=%b blink=%b exp=100000/1", pulses, o_blink_on); end
    for (int t = 1; t <= TO; t++) begin
      step(1, 0, 0, 0);
      n_cmp++;
      if (o_edit_field !== ((t < TO) ? 2'd1 : 2'd0) || o_blink_on !== ((t < TO) ? ((t / BL) % 2 == 0) : 1'b1) || obs !== mdl)
        begin n_err++; $display("FAIL timeout t=%0d field=%0d blink=%b mdl=%b", t, o_edit_field, o_blink_on, mdl); end
    end
  endtask

  task automatic test_simultaneous();
    step(1, 1, 0, 0); step(1, 0, 0, 0);
    step(1, 1, 1, 0);
    n_cmp++;
    if (o_edit_field !== 2'd2 || pulses !== 6'd0 || obs !== mdl) begin n_err++; $display("FAIL mode_and_up field=%0d pulses=%b exp=2/000000", o_edit_field, pulses); end
    step(1, 0, 0, 0);
    step(1, 0, 1, 1);
    n_cmp++;
    if (pulses !== 6'd0) begin n_err++; $display("FAIL up_down_together got=%b exp=000000", pulses); end
    step(1, 0, 1, 1); step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 1);
    n_cmp++;
    if (pulses !== 6'd0 || obs !== mdl) begin n_err++; $display("FAIL down_while_up got=%b exp=000000", pulses); end
    step(1, 0, 0, 0);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0);
    step(0, 0, 1, 0);
    n_cmp++;
    if (obs !== 9'b000000001) begin n_err++; $display("FAIL mid_reset got=%b exp=%b", obs, 9'b000000001); end
    step(1, 0, 0, 0);
    n_cmp++;
    if (obs !== 9'b000000001 || obs !== mdl) begin n_err++; $display("FAIL post_reset got=%b exp=%b", obs, 9'b000000001); end
  endtask

  task automatic test_random();
    int left = 0, r;
    bit m = 0, u = 0, d = 0;
    for (int i = 0; i < 4000; i++) begin
      if (left == 0) begin
        r = $urandom_range(0, 9);
        m = r == 0; u = r inside {[1:3], 7}; d = r inside {[4:7]};
        left = (r >= 8) ? $urandom_range(1, 40) : $urandom_range(1, 14);
      end
      left--;
      step($urandom_range(0, 299) != 0, m, u, d);
      n_cmp++;
      if (obs !== mdl) begin n_err++; if (n_err < 20) $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs, mdl); end
      n_cmp++;
      if ($countones(pulses) > 1) begin n_err++; $display("FAIL onehot cyc=%0d pulses=%b", cyc, pulses); end
    end
  endtask

  initial begin
    test_reset();
    test_mode();
    test_field_pulse();
    test_autorepeat();
    test_timeout_blink();
    test_simultaneous();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/watch_set_ctrl.md
Name: watch_set_ctrl

Overview:
- Control unit for the watch time-setting datapath. Takes debounced button levels and runs an edit-mode FSM: RUN, then EDIT_HOUR, EDIT_MIN, EDIT_SEC.
- Emits single-cycle up/down pulses to the hour/min/sec counters, plus field-select and blink status for the FND display mux.
- Sits between the button debouncers and the watch datapath. Holds no time value itself.

Parameters:
- HOLD_CYCLES, 50_000_000, clk cycles a button must stay held before the first auto-repeat pulse (0.5 s at 100 MHz).
- REPEAT_CYCLES, 10_000_000, clk cycles between subsequent auto-repeat pulses.
- TIMEOUT_CYCLES, 1_000_000_000, clk cycles of no button activity in an edit state before the FSM forces RUN.
- BLINK_CYCLES, 25_000_000, clk cycles per half-period of o_blink_on.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  synchronous, active-low reset, sampled on posedge clk.
- i_btn_mode  input  1  debounced level, mode button.
- i_btn_up  input  1  debounced level, up button.
- i_btn_down  input  1  debounced level, down button.
- o_hour_up, o_hour_down  output  1 each  one-cycle pulses to the hour counter.
- o_min_up, o_min_down  output  1 each  one-cycle pulses to the minute counter.
- o_sec_up, o_sec_down  output  1 each  one-cycle pulses to the second counter.
- o_edit_field  output  2  current field: 0=RUN, 1=HOUR, 2=MIN, 3=SEC.
- o_blink_on  output  1  1 = display the selected field, 0 = blank it.

Behaviour:
- Single clock domain. Reset is synchronous and active-low: rst==0 at a posedge resets the block.
- Reset values: all six pulse outputs 0, o_edit_field=0, o_blink_on=1. All counters 0 and all edge-detect history registers 0.
- Edge detect: a rising edge on a button means the input was sampled 1 at posedge k and 0 at posedge k-1. All outputs are registered, so the resulting pulse appears in the cycle after posedge k.
- FSM on a rising edge of i_btn_mode: RUN->EDIT_HOUR->EDIT_MIN->EDIT_SEC->RUN. One step per edge; a held mode button does not re-trigger.
- Field pulses:
  - In RUN, up/down are ignored and no pulses are issued.
  - In an edit state, a rising edge of up produces exactly one pulse on <field>_up; down likewise produces one pulse on <field>_down.
- Simultaneous events:
  - up and down both high in the same sample: no pulse, and the repeat counter is cleared.
  - A mode edge in the same cycle as an up/down edge: the mode change wins, no field pulse is issued, and the repeat counter is cleared.
- Timeout:
  - The counter clears on any rising edge or any held button. Otherwise it increments in edit states and holds at 0 in RUN.
  - When it reaches TIMEOUT_CYCLES-1, the FSM goes to RUN on the next posedge and the counter clears.
- Blink:
  - In RUN, o_blink_on is constantly 1.
  - In edit states it toggles every BLINK_CYCLES cycles. The blink counter restarts and o_blink_on is forced to 1 on every field change and on every issued pulse, so the edited value stays visible.
- At most one of the six pulse outputs is high in any cycle.
- Reset mid-operation (including during a hold or repeat): next cycle shows reset values, with no residual pulse.
- Counter widths are sized with $clog2 of the parameter. Counters never wrap: they saturate or clear as specified above.

Optional Feature:
- Macro WATCH_SET_CTRL_AUTOREPEAT_EN.
- Defined:
  - While exactly one of up/down stays held in an edit state, the hold counter counts from the press edge.
  - After HOLD_CYCLES cycles of hold (counted from the press edge), one extra pulse is issued, then one every REPEAT_CYCLES cycles until release.
  - Release, a mode edge, a timeout or reset clears the counter.
- Undefined: one pulse per press only, and the hold/repeat counters are not synthesized. HOLD_CYCLES and REPEAT_CYCLES are unused.

Test Plan:
All runs use HOLD=8, REPEAT=4, TIMEOUT=32, BLINK=5.
1. Hold rst=0 for 3 cycles with buttons toggling -> all pulses 0, o_edit_field=0, o_blink_on=1. Release, then up edge in RUN -> no pulse.
2. Four mode edges spaced 3 cycles apart -> o_edit_field 1,2,3,0, each change one cycle after its edge. Hold mode high 20 cycles -> only one step.
3. In EDIT_MIN, up edge at posedge k -> o_min_up=1 only in cycle k+1. Then down edge -> one o_min_down pulse, all other outputs 0.
4. AUTOREPEAT_EN on, EDIT_SEC, hold up 20 cycles -> o_sec_up pulses at cycles +1, +9, +13, +17 relative to the press edge. Without the macro -> only the +1 pulse.
5. Enter EDIT_HOUR and stay idle -> o_blink_on toggles every 5 cycles, and o_edit_field returns to 0 exactly 32 cycles after the last activity. Any press at cycle 20 restarts the count.
6. Mode edge and up edge in the same cycle in EDIT_HOUR -> field goes to 2 with no hour/min pulse. Up and down high together -> no pulse.
